// File: rtl/rf_pkg.sv
// Register file shared constants and writeback requester indices.
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at rr_ptr and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // rr_ptr is always below NUM_REQ, so one subtraction is enough to wrap
    function automatic logic [PTR_W-1:0] slot(
        input logic [PTR_W-1:0] p,
        input int               k
    );
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && req_valid[slot(rr_ptr, k)]) begin
                grant_valid             = 1'b1;
                grant[slot(rr_ptr, k)]  = 1'b1;
                grant_idx               = slot(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates writeback sources onto the single register file write port
// and tracks pending destination writes in a busy scoreboard.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      set_en,
    input  logic [ADDR_W-1:0]         set_addr,
    input  logic                      flush,
    output logic                      rg_wrt_en,
    output logic [ADDR_W-1:0]         rg_wrt_addr,
    output logic [DATA_W-1:0]         rg_wrt_data,
    output logic [RF_NUM_REGS-1:0]    busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]     grant;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_data;
    logic [RF_NUM_REGS-1:0] busy_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;
    assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    // A new producer issued this cycle outranks both the completing write and flush
    always_comb begin
        busy_nxt = busy;
        if (rg_wrt_en) busy_nxt[rg_wrt_addr] = 1'b0;
        if (flush) busy_nxt = '0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
            busy        <= '0;
        end else begin
            busy      <= busy_nxt;
            rg_wrt_en <= grant_valid && (sel_addr != '0);
            if (grant_valid) begin
                rg_wrt_addr <= sel_addr;
                rg_wrt_data <= sel_data;
                if (int'(grant_idx) == NUM_REQ - 1)
                    rr_ptr <= '0;
                else
                    rr_ptr <= grant_idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter with a cycle reference model.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          set_en;
    logic [4:0]    set_addr;
    logic          flush;
    logic          rg_wrt_en;
    logic [4:0]    rg_wrt_addr;
    logic [31:0]   rg_wrt_data;
    logic [31:0]   busy;

    logic [N-1:0]  v;
    logic [4:0]    a [N];
    logic [31:0]   d [N];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_ptr;
    bit          m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    int          last_grant;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    always_comb begin
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_addr[i*5 +: 5]   = a[i];
            req_data[i*32 +: 32] = d[i];
        end
    end

    always @(posedge clk)
        if (rg_wrt_en) rf[rg_wrt_addr] <= rg_wrt_data;

    rf_wb_arbiter #(.NUM_REQ(N), .ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .set_en      (set_en),
        .set_addr    (set_addr),
        .flush       (flush),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_addr (rg_wrt_addr),
        .rg_wrt_data (rg_wrt_data),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_en   = 0;
        m_addr = '0;
        m_data = '0;
        m_busy = '0;
    endtask

    task automatic idle_inputs();
        v = '0;
        set_en = 0;
        set_addr = '0;
        flush = 0;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_en", 32'(rg_wrt_en), 0);
        check("rst_addr", 32'(rg_wrt_addr), 0);
        check("rst_data", rg_wrt_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: check at negedge against the model, then advance the model
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        logic [31:0] nb;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && v[i]) g = i;
        end
        exp_rdy = (g < 0) ? '0 : N'(1 << g);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("wrt_en", 32'(rg_wrt_en), 32'(m_en));
        check("wrt_addr", 32'(rg_wrt_addr), 32'(m_addr));
        check("wrt_data", rg_wrt_data, m_data);
        check("busy", busy, m_busy);
        last_grant = g;
        nb = m_busy;
        if (m_en) nb[m_addr] = 1'b0;
        if (flush) nb = '0;
        if (set_en && set_addr != 0) nb[set_addr] = 1'b1;
        m_busy = nb;
        m_en = 0;
        if (g >= 0) begin
            m_en   = (a[g] != 0);
            m_addr = a[g];
            m_data = d[g];
            m_ptr  = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = '0;
        idle_inputs();
        model_reset();
        last_grant = -1;
        #2;
        do_reset();
        repeat (5) step();

        // single write with scoreboard set/clear
        set_en = 1; set_addr = 5;
        step();
        set_en = 0;
        v = 3'b001; a[WB_ALU] = 5; d[WB_ALU] = 32'hDEADBEEF;
        step();
        check("busy5_set", 32'(busy[5]), 1);
        v = '0;
        step();
        step();
        check("busy5_clr", 32'(busy[5]), 0);
        check("rf_x5", rf[5], 32'hDEADBEEF);

        // round-robin fairness
        do_reset();
        v = 3'b111;
        a[0] = 1; a[1] = 2; a[2] = 3;
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
        for (int c = 0; c < 6; c++) begin
            step();
            check("rr_order", 32'(last_grant), 32'(c % N));
        end
        v = '0;
        step();
        step();

        // x0 write: granted, no write, pointer still moves
        v = 3'b010; a[WB_LSU] = 0; d[WB_LSU] = 32'h1234;
        step();
        check("x0_grant", 32'(last_grant), 1);
        v = '0;
        step();
        check("x0_rf", rf[0], 0);
        v = 3'b111; a[0] = 10; a[1] = 11; a[2] = 12;
        step();
        check("x0_ptr", 32'(last_grant), 2);
        v = '0;
        step();
        step();

        // set/clear collision on x7
        set_en = 1; set_addr = 7;
        step();
        set_en = 0;
        v = 3'b001; a[0] = 7; d[0] = 32'h77;
        step();
        v = '0;
        set_en = 1; set_addr = 7;
        step();
        set_en = 0;
        step();
        check("collide_busy7", 32'(busy[7]), 1);
        v = 3'b001;
        step();
        v = '0;
        step();
        step();

        // flush keeps simultaneous set and the in-flight write
        set_en = 1; set_addr = 3;
        step();
        set_addr = 9;
        step();
        set_en = 0;
        v = 3'b001; a[0] = 9; d[0] = 32'h99;
        step();
        v = '0;
        flush = 1; set_en = 1; set_addr = 4;
        check("flush_inflight", 32'(rg_wrt_en), 1);
        step();
        flush = 0; set_en = 0;
        step();
        check("flush_busy", busy, 32'h10);
        check("flush_rf9", rf[9], 32'h99);

        // randomized traffic with requesters holding until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    a[i] = 5'($urandom_range(0, 31));
                    d[i] = $urandom;
                end
            end
            set_en   = ($urandom_range(0, 2) == 0);
            set_addr = 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 19) == 0);
            step();
            if (last_grant >= 0) v[last_grant] = 1'b0;
            if (c % 97 == 50 && m_en) begin
                reset = 1'b1;
                #1;
                check("midrst_en", 32'(rg_wrt_en), 0);
                check("midrst_busy", busy, 0);
                #1;
                reset = 1'b0;
                model_reset();
                v = '0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
